// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the RV32 memory stage: little-endian
// byte/half/word loads and stores, configurable wait states, and a busy stall.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req, misalign, illegal, acc_err;
  logic [3:0]    be;
  logic [31:0]   word, wrep, wmerge, ldval;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;
  logic          unused_addr_hi;

  // Address bits above the word index alias by design.
  assign unused_addr_hi = ^addr[31:IW+2];
  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
    idx_q   <= idx_d;
    off_q   <= off_d;
    f3_q    <= f3_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = addr[IW+1:2];
          off_d   = addr[1:0];
          f3_d    = funct3;
          rd_d    = mem_read;
          wr_d    = mem_write;
          wdata_d = wdata;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access checks and datapath, all from values latched at accept.
  always_comb begin
    case (f3_q[1:0])
      2'b01:   misalign = off_q[0];
      2'b10:   misalign = (off_q != 2'b00);
      default: misalign = 1'b0;
    endcase
    if (wr_q) illegal = f3_q[2] || (f3_q[1:0] == 2'b11);
    else      illegal = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11);
    acc_err = (rd_q & wr_q) | misalign | illegal;

    case (f3_q[1:0])
      2'b00:   be = 4'b0001 << off_q;
      2'b01:   be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (f3_q[1:0])
      2'b00:   wrep = {4{wdata_q[7:0]}};
      2'b01:   wrep = {2{wdata_q[15:0]}};
      default: wrep = wdata_q;
    endcase

    word = mem_q[idx_q];
    for (int unsigned i = 0; i < 4; i++) begin
      wmerge[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
    end

    lbyte = word[{off_q, 3'b000} +: 8];
    lhalf = off_q[1] ? word[31:16] : word[15:0];
    case (f3_q)
      3'b000:  ldval = {{24{lbyte[7]}}, lbyte};
      3'b001:  ldval = {{16{lhalf[15]}}, lhalf};
      3'b100:  ldval = {24'h0, lbyte};
      3'b101:  ldval = {16'h0, lhalf};
      default: ldval = word;
    endcase

    rdata_d = rdata_q;
    if (state_q == RESP) begin
      if (acc_err)   rdata_d = '0;
      else if (rd_q) rdata_d = ldval;
    end
  end

  // A reset landing on the RESP edge abandons the write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && wr_q && !acc_err) mem_q[idx_q] <= wmerge;
  end

  always_comb begin
    busy  = (state_q == WAIT) || (state_q == IDLE && req);
    done  = (state_q == RESP);
    err   = (state_q == RESP) && acc_err;
    rdata = rdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_STATES=2, one with 0,
// both checked against a byte-addressed reference model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst2, rd2, wr2, busy2, done2, err2;
  logic [2:0]  f2;
  logic [31:0] a2, wd2, rdat2;
  logic        rst0, rd0, wr0, busy0, done0, err0;
  logic [2:0]  f0;
  logic [31:0] a0, wd0, rdat0;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mm [2][256];
  logic [31:0] exp_hold [2];

  typedef struct {
    bit got; int lat; int nbusy; bit bd;
    bit e; logic [31:0] r; bit ee; logic [31:0] er;
  } res_t;

  typedef struct {
    bit rd; bit wr; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
    bit e; logic [31:0] r;
  } vec_t;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(rst2), .mem_read(rd2), .mem_write(wr2), .funct3(f2),
    .addr(a2), .wdata(wd2), .rdata(rdat2), .busy(busy2), .done(done2), .err(err2));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .mem_read(rd0), .mem_write(wr0), .funct3(f0),
    .addr(a0), .wdata(wd0), .rdata(rdat0), .busy(busy0), .done(done0), .err(err0));

  // Reference: memory as a byte array view over 256 words, accesses as byte sequences.
  task automatic model_op(input int s, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, output bit e);
    int unsigned sz, ba, w, sh;
    logic [31:0] v;
    bit legal;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    e = (rd && wr) || !legal || ((a % sz) != 0);
    if (e) begin
      exp_hold[s] = '0;
      return;
    end
    if (wr) begin
      for (int unsigned k = 0; k < sz; k++) begin
        ba = a + k; w = (ba >> 2) % 256; sh = 8 * (ba % 4);
        mm[s][w] = (mm[s][w] & ~(32'hFF << sh)) | (((wd >> (8 * k)) & 32'hFF) << sh);
      end
    end else begin
      v = '0;
      for (int unsigned k = 0; k < sz; k++) begin
        ba = a + k; w = (ba >> 2) % 256; sh = 8 * (ba % 4);
        v = v | (((mm[s][w] >> sh) & 32'hFF) << (8 * k));
      end
      if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 1);
      exp_hold[s] = v;
    end
  endtask

  task automatic drive(input int s, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s == 0) begin rd2 = rd; wr2 = wr; f2 = f3; a2 = a; wd2 = wd; end
    else        begin rd0 = rd; wr0 = wr; f0 = f3; a0 = a; wd0 = wd; end
  endtask

  // Issues one request, drops it after accept, and reports what the DUT did.
  task automatic run_op(input int s, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output res_t res);
    bit eexp;
    res = '{got: 1'b0, lat: 0, nbusy: 0, bd: 1'b0, e: 1'b0, r: '0, ee: 1'b0, er: '0};
    @(negedge clk);
    drive(s, rd, wr, f3, a, wd);
    #1;
    for (int c = 0; c < 12; c++) begin
      if ((s == 0) ? done2 : done0) begin
        res.got = 1'b1; res.lat = c;
        res.e  = (s == 0) ? err2 : err0;
        res.bd = (s == 0) ? busy2 : busy0;
        break;
      end
      if ((s == 0) ? busy2 : busy0) res.nbusy++;
      @(posedge clk); #1;
      if (c == 0) drive(s, 1'b0, 1'b0, 3'd0, '0, '0);
    end
    drive(s, 1'b0, 1'b0, 3'd0, '0, '0);
    @(posedge clk); #1;
    res.r = (s == 0) ? rdat2 : rdat0;
    model_op(s, rd, wr, f3, a, wd, eexp);
    res.ee = eexp;
    res.er = exp_hold[s];
  endtask

  task automatic test_reset;
    rst2 = 1'b1; rst0 = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 1'b0, 3'd0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({busy2, done2, err2} !== 3'b000 || rdat2 !== 32'h0) begin
      nmis++; $display("FAIL reset_ws2: got busy/done/err=%b rdata=%h want 000 00000000", {busy2, done2, err2}, rdat2);
    end
    nvec++;
    if ({busy0, done0, err0} !== 3'b000 || rdat0 !== 32'h0) begin
      nmis++; $display("FAIL reset_ws0: got busy/done/err=%b rdata=%h want 000 00000000", {busy0, done0, err0}, rdat0);
    end
    rst2 = 1'b0; rst0 = 1'b0;
    exp_hold[0] = '0; exp_hold[1] = '0;
  endtask

  task automatic init_mem;
    res_t r;
    for (int w = 0; w < 32; w++) begin
      run_op(0, 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, r);
      run_op(1, 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, r);
    end
  endtask

  task automatic test_directed;
    vec_t t[$];
    res_t r;
    t.push_back('{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0});
    t.push_back('{1, 0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF});
    t.push_back('{0, 1, 3'b000, 32'h11, 32'h00000080, 0, 32'h0});
    t.push_back('{1, 0, 3'b000, 32'h11, 32'h0,        0, 32'hFFFFFF80});
    t.push_back('{1, 0, 3'b100, 32'h11, 32'h0,        0, 32'h00000080});
    t.push_back('{1, 0, 3'b010, 32'h10, 32'h0,        0, 32'hDEAD80EF});
    t.push_back('{0, 1, 3'b010, 32'h20, 32'h12345678, 0, 32'h0});
    t.push_back('{0, 1, 3'b001, 32'h22, 32'h00008001, 0, 32'h0});
    t.push_back('{1, 0, 3'b001, 32'h22, 32'h0,        0, 32'hFFFF8001});
    t.push_back('{1, 0, 3'b101, 32'h22, 32'h0,        0, 32'h00008001});
    t.push_back('{1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h80015678});
    t.push_back('{1, 0, 3'b010, 32'h13, 32'h0,        1, 32'h0});
    t.push_back('{0, 1, 3'b001, 32'h21, 32'h0000FFFF, 1, 32'h0});
    t.push_back('{1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h80015678});
    t.push_back('{1, 1, 3'b010, 32'h20, 32'h0,        1, 32'h0});
    t.push_back('{1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h80015678});
    t.push_back('{0, 1, 3'b011, 32'h20, 32'h0,        1, 32'h0});
    t.push_back('{1, 0, 3'b110, 32'h20, 32'h0,        1, 32'h0});
    t.push_back('{1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h80015678});
    foreach (t[i]) begin
      run_op(0, t[i].rd, t[i].wr, t[i].f3, t[i].a, t[i].wd, r);
      nvec++;
      if (!r.got || r.lat != 3 || r.nbusy != 3 || r.bd) begin
        nmis++; $display("FAIL dir_timing[%0d]: got done=%0b lat=%0d busy=%0d busy@done=%0b want 1 3 3 0", i, r.got, r.lat, r.nbusy, r.bd);
      end
      nvec++;
      if (r.e !== t[i].e) begin
        nmis++; $display("FAIL dir_err[%0d]: got %0b want %0b", i, r.e, t[i].e);
      end
      if (t[i].rd || t[i].e) begin
        nvec++;
        if (r.r !== t[i].r) begin
          nmis++; $display("FAIL dir_rdata[%0d]: got %h want %h", i, r.r, t[i].r);
        end
      end
    end
  endtask

  task automatic test_random(input int s, input int n);
    res_t r;
    bit rd, wr;
    int k, wantlat;
    logic [31:0] a;
    wantlat = (s == 0) ? 3 : 1;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      rd = (k == 0) || (k >= 5);
      wr = (k <= 4);
      a = 32'($urandom_range(0, 127)) | ($urandom << 10);
      run_op(s, rd, wr, 3'($urandom_range(0, 7)), a, $urandom, r);
      nvec++;
      if (!r.got || r.lat != wantlat || r.nbusy != wantlat || r.bd) begin
        nmis++; $display("FAIL rnd_timing[%0d/%0d]: got done=%0b lat=%0d busy=%0d busy@done=%0b want 1 %0d %0d 0", s, i, r.got, r.lat, r.nbusy, r.bd, wantlat, wantlat);
      end
      nvec++;
      if (r.e !== r.ee || r.r !== r.er) begin
        nmis++; $display("FAIL rnd_result[%0d/%0d]: got err=%0b rdata=%h want err=%0b rdata=%h", s, i, r.e, r.r, r.ee, r.er);
      end
    end
  endtask

  task automatic test_reset_inflight;
    res_t r;
    logic [31:0] old;
    bit seen;
    old = mm[0][16];
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h55AA55AA);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    exp_hold[0] = '0;
    nvec++;
    if (busy2 !== 1'b0 || rdat2 !== 32'h0) begin
      nmis++; $display("FAIL rst_inflight_state: got busy=%0b rdata=%h want 0 00000000", busy2, rdat2);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    nvec++;
    if (seen) begin
      nmis++; $display("FAIL rst_inflight_done: got done pulse=1 want 0");
    end
    run_op(0, 1'b1, 1'b0, 3'b010, 32'h40, '0, r);
    nvec++;
    if (!r.got || r.e || r.r !== old) begin
      nmis++; $display("FAIL rst_inflight_nowrite: got done=%0b err=%0b rdata=%h want 1 0 %h", r.got, r.e, r.r, old);
    end
  endtask

  task automatic test_back_to_back;
    res_t r;
    logic [31:0] d;
    bit eexp;
    d = $urandom;
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 3'b010, 32'h30, d);
    for (int i = 0; i < 6; i++) begin
      #1;
      nvec++;
      if (busy0 !== (i % 2 == 0) || done0 !== (i % 2 == 1) || err0 !== 1'b0) begin
        nmis++; $display("FAIL b2b_cycle[%0d]: got busy=%0b done=%0b err=%0b want %0b %0b 0", i, busy0, done0, err0, i % 2 == 0, i % 2 == 1);
      end
      @(negedge clk);
    end
    drive(1, 1'b0, 1'b0, 3'd0, '0, '0);
    model_op(1, 1'b0, 1'b1, 3'b010, 32'h30, d, eexp);
    run_op(1, 1'b1, 1'b0, 3'b010, 32'h30, '0, r);
    nvec++;
    if (r.r !== d) begin
      nmis++; $display("FAIL b2b_data: got %h want %h", r.r, d);
    end
    d = $urandom;
    run_op(1, 1'b0, 1'b1, 3'b010, 32'h400, d, r);
    nvec++;
    if (r.e !== 1'b0) begin
      nmis++; $display("FAIL alias_store_err: got %0b want 0", r.e);
    end
    run_op(1, 1'b1, 1'b0, 3'b010, 32'h0, '0, r);
    nvec++;
    if (r.r !== d || r.r !== r.er) begin
      nmis++; $display("FAIL alias_load: got %h want %h", r.r, d);
    end
  endtask

  initial begin
    test_reset;
    init_mem;
    test_directed;
    test_random(0, 60);
    test_random(1, 80);
    test_reset_inflight;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
